// File: rtl/cordic_pipe.sv
// Parametrised, fully pipelined CORDIC (rotation/vectoring per sample) with whole-pipe stall.
// Optional output gain compensation stage enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_pipe #(
    parameter int unsigned WIDTH  = 13,
    parameter int unsigned FRAC   = 10,
    parameter int unsigned STAGES = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic signed [WIDTH-1:0] in_z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_mode,
    output logic signed [WIDTH-1:0] out_x,
    output logic signed [WIDTH-1:0] out_y,
    output logic signed [WIDTH-1:0] out_z
);

    // Constants are held at Q2.30 and rounded to the FRAC-bit grid.
    localparam int unsigned SH = (FRAC >= 30) ? 0 : 30 - FRAC;
    localparam int unsigned UP = (FRAC > 30) ? FRAC - 30 : 0;

    function automatic logic [63:0] scale_q30(input logic [63:0] v);
        return ((v + ((64'd1 << SH) >> 1)) >> SH) << UP;
    endfunction

    function automatic logic signed [WIDTH-1:0] atan_q(input int unsigned k);
        logic [63:0] t;
        case (k)
            'd0:  t = 64'h3243_F6A8;
            'd1:  t = 64'h1DAC_6705;
            'd2:  t = 64'h0FAD_BAFC;
            'd3:  t = 64'h07F5_6EA6;
            'd4:  t = 64'h03FE_AB76;
            'd5:  t = 64'h01FF_D55B;
            'd6:  t = 64'h00FF_FAAA;
            'd7:  t = 64'h007F_FF55;
            'd8:  t = 64'h003F_FFEA;
            'd9:  t = 64'h001F_FFFD;
            'd10: t = 64'h000F_FFFF;
            'd11: t = 64'h0007_FFFF;
            'd12: t = 64'h0003_FFFF;
            'd13: t = 64'h0001_FFFF;
            'd14: t = 64'h0000_FFFF;
            'd15: t = 64'h0000_7FFF;
            default: t = 64'h0;
        endcase
        return $signed(WIDTH'(scale_q30(t)));
    endfunction

    logic signed [WIDTH-1:0] x_q [STAGES];
    logic signed [WIDTH-1:0] y_q [STAGES];
    logic signed [WIDTH-1:0] z_q [STAGES];
    logic                    m_q [STAGES];
    logic                    v_q [STAGES];

    logic signed [WIDTH-1:0] xi [STAGES];
    logic signed [WIDTH-1:0] yi [STAGES];
    logic signed [WIDTH-1:0] zi [STAGES];
    logic                    mi [STAGES];
    logic                    vi [STAGES];
    logic signed [WIDTH-1:0] xn [STAGES];
    logic signed [WIDTH-1:0] yn [STAGES];
    logic signed [WIDTH-1:0] zn [STAGES];

    assign in_ready = !(out_valid && !out_ready);

    // Stage inputs and one micro-rotation per stage.
    always_comb begin
        xi = '{default: '0};
        yi = '{default: '0};
        zi = '{default: '0};
        mi = '{default: 1'b0};
        vi = '{default: 1'b0};
        xn = '{default: '0};
        yn = '{default: '0};
        zn = '{default: '0};
        xi[0] = in_x;
        yi[0] = in_y;
        zi[0] = in_z;
        mi[0] = in_mode;
        vi[0] = in_valid;
        for (int unsigned i = 1; i < STAGES; i++) begin
            xi[i] = x_q[i-1];
            yi[i] = y_q[i-1];
            zi[i] = z_q[i-1];
            mi[i] = m_q[i-1];
            vi[i] = v_q[i-1];
        end
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (mi[i] ? yi[i][WIDTH-1] : !zi[i][WIDTH-1]) begin
                xn[i] = xi[i] - (yi[i] >>> i);
                yn[i] = yi[i] + (xi[i] >>> i);
                zn[i] = zi[i] - atan_q(i);
            end else begin
                xn[i] = xi[i] + (yi[i] >>> i);
                yn[i] = yi[i] - (xi[i] >>> i);
                zn[i] = zi[i] + atan_q(i);
            end
        end
    end

    // Bubbles advance their valid bit only; data registers load on valid samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                z_q[i] <= '0;
                m_q[i] <= 1'b0;
                v_q[i] <= 1'b0;
            end
        end else if (in_ready) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                v_q[i] <= vi[i];
                if (vi[i]) begin
                    x_q[i] <= xn[i];
                    y_q[i] <= yn[i];
                    z_q[i] <= zn[i];
                    m_q[i] <= mi[i];
                end
            end
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int unsigned PW = 2 * WIDTH;
    localparam logic signed [WIDTH-1:0] KINV = $signed(WIDTH'(scale_q30(64'd652032837)));

    logic signed [PW-1:0]    px;
    logic signed [PW-1:0]    py;
    logic signed [WIDTH-1:0] g_x;
    logic signed [WIDTH-1:0] g_y;
    logic signed [WIDTH-1:0] g_z;
    logic                    g_m;
    logic                    g_v;

    assign px = PW'(x_q[STAGES-1]) * PW'(KINV);
    assign py = PW'(y_q[STAGES-1]) * PW'(KINV);

    // Extra register stage removing the accumulated CORDIC gain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_x <= '0;
            g_y <= '0;
            g_z <= '0;
            g_m <= 1'b0;
            g_v <= 1'b0;
        end else if (in_ready) begin
            g_v <= v_q[STAGES-1];
            if (v_q[STAGES-1]) begin
                g_x <= WIDTH'(px >>> FRAC);
                g_y <= WIDTH'(py >>> FRAC);
                g_z <= z_q[STAGES-1];
                g_m <= m_q[STAGES-1];
            end
        end
    end

    assign out_valid = g_v;
    assign out_mode  = g_m;
    assign out_x     = g_x;
    assign out_y     = g_y;
    assign out_z     = g_z;
`else
    assign out_valid = v_q[STAGES-1];
    assign out_mode  = m_q[STAGES-1];
    assign out_x     = x_q[STAGES-1];
    assign out_y     = y_q[STAGES-1];
    assign out_z     = z_q[STAGES-1];
`endif

endmodule

// File: tb/tb_cordic_pipe.sv
// Scoreboard bench for cordic_pipe: bit-exact reference model, stalls, bubbles, mid-stream reset.
module tb_cordic_pipe;

    localparam int unsigned WIDTH  = 13;
    localparam int unsigned FRAC   = 10;
    localparam int unsigned STAGES = 10;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = STAGES + 1;
`else
    localparam int LAT = STAGES;
`endif
    localparam int ANG [10] = '{804, 475, 251, 127, 64, 32, 16, 8, 4, 2};

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_mode;
    logic signed [WIDTH-1:0] in_x, in_y, in_z;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_mode;
    logic signed [WIDTH-1:0] out_x, out_y, out_z;

    cordic_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_x(out_x), .out_y(out_y), .out_z(out_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [12:0] x, y, z;
        logic               m;
        int                 acc;
        int                 st;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0, n_bad = 0;
    int   cyc = 0, stalls = 0, pops = 0;
    int   sa = -100, sb = -100, sc = -100;
    bit   force_stall = 1'b0, accepted = 1'b0;
    logic signed [12:0] last_x, last_y, last_z;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic signed [12:0] x0, y0, z0, input logic m);
        exp_t e;
        logic signed [12:0] x, y, z, xs, ys;
`ifdef CORDIC_GAIN_COMP_EN
        logic signed [25:0] p;
`endif
        x = x0; y = y0; z = z0;
        for (int i = 0; i < 10; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if (m ? y[12] : !z[12]) begin
                x = x - ys; y = y + xs; z = z - 13'(ANG[i]);
            end else begin
                x = x + ys; y = y - xs; z = z + 13'(ANG[i]);
            end
        end
`ifdef CORDIC_GAIN_COMP_EN
        p = 26'(x) * 26'sd622;
        x = 13'(p >>> 10);
        p = 26'(y) * 26'sd622;
        y = 13'(p >>> 10);
`endif
        e.x = x; e.y = y; e.z = z; e.m = m; e.acc = 0; e.st = 0;
        return e;
    endfunction

    function automatic int in_tol(input int v, input int c, input int t);
        return (v >= c - t && v <= c + t) ? 1 : 0;
    endfunction

    function automatic int rnd(input int lo, input int hi);
        return lo + int'($urandom_range(unsigned'(hi - lo)));
    endfunction

    function automatic bit ready_now();
        return !(force_stall || (cyc >= sa && cyc < sa + 5) ||
                 (cyc >= sb && cyc < sb + 5) || (cyc >= sc && cyc < sc + 5));
    endfunction

    // One clock: inputs are set at the falling edge, handshakes are evaluated just after it.
    task automatic cycle();
        exp_t e;
        out_ready = ready_now();
        #1;
        accepted = 1'b0;
        if (out_valid && !out_ready) begin
            stalls++;
            check("stall_in_ready", in_ready, 0);
            if (sbq.size() > 0) begin
                check("stall_hold_x", out_x, sbq[0].x);
                check("stall_hold_y", out_y, sbq[0].y);
                check("stall_hold_z", out_z, sbq[0].z);
            end else check("stall_spurious", out_valid, 0);
        end
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) check("spurious_out", out_valid, 0);
            else begin
                e = sbq.pop_front();
                check("out_x", out_x, e.x);
                check("out_y", out_y, e.y);
                check("out_z", out_z, e.z);
                check("out_mode", out_mode, e.m);
                check("latency", cyc - e.acc, LAT + stalls - e.st);
                last_x = out_x; last_y = out_y; last_z = out_z;
                pops++;
            end
        end
        if (in_valid && in_ready) begin
            e = model(in_x, in_y, in_z, in_mode);
            e.acc = cyc;
            e.st  = stalls;
            sbq.push_back(e);
            accepted = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input int x, input int y, input int z, input logic m);
        in_x = 13'(x); in_y = 13'(y); in_z = 13'(z); in_mode = m;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            cycle();
            if (accepted) break;
        end
        check("send_accepted", accepted, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 200 && sbq.size() > 0; k++) cycle();
        check("drain_left", sbq.size(), 0);
    endtask

    task automatic send_random();
        if ($urandom_range(1) == 0)
            send(rnd(-1500, 1500), rnd(-1500, 1500), rnd(-1700, 1700), 1'b0);
        else
            send(rnd(1, 1500), rnd(-1500, 1500), rnd(-500, 500), 1'b1);
    endtask

    initial begin
        int p0, st0;
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0;
        in_x = '0; in_y = '0; in_z = '0; out_ready = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_x", out_x, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        for (int k = 0; k < 20; k++) begin
            check("idle_valid", out_valid, 0);
            check("idle_mode", out_mode, 0);
            check("idle_x", out_x, 0);
            check("idle_y", out_y, 0);
            check("idle_z", out_z, 0);
            check("idle_ready", in_ready, 1);
            cycle();
        end

`ifdef CORDIC_GAIN_COMP_EN
        send(1000, 0, 0, 1'b0); drain();
        check("gain_x_tol", in_tol(last_x, 1000, 6), 1);
`else
        send(622, 0, 0, 1'b0); drain();
        check("rot0_x_tol", in_tol(last_x, 1024, 4), 1);
        check("rot0_y_tol", in_tol(last_y, 0, 4), 1);
        check("rot0_z_tol", in_tol(last_z, 0, 2), 1);
        send(622, 0, 804, 1'b0); drain();
        check("rot45_x_tol", in_tol(last_x, 724, 6), 1);
        check("rot45_y_tol", in_tol(last_y, 724, 6), 1);
        send(300, 400, 0, 1'b1); drain();
        check("vec_x_tol", in_tol(last_x, 823, 6), 1);
        check("vec_y_tol", in_tol(last_y, 0, 4), 1);
        check("vec_z_tol", in_tol(last_z, 950, 3), 1);
`endif

        // Back-to-back alternating modes
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) send(622, 0, 804, 1'b0);
            else            send(300, 400, 0, 1'b1);
        end
        drain();

        // Backpressure with bubbles and three 5-cycle stall windows
        p0 = pops; st0 = stalls;
        sa = cyc + rnd(12, 18);
        sb = sa + rnd(7, 14);
        sc = sb + rnd(7, 14);
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(3) == 0) cycle();
            send_random();
        end
        drain();
        check("bp_count", pops - p0, 30);
        check("bp_stall_seen", (stalls > st0) ? 1 : 0, 1);
        sa = -100; sb = -100; sc = -100;

        // Reset with six samples in flight, the oldest held at the output
        force_stall = 1'b1;
        for (int k = 0; k < 6; k++) send_random();
        for (int k = 0; k < 20 && !out_valid; k++) cycle();
        check("rst_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_x", out_x, 0);
        check("rst_mid_ready", in_ready, 1);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        force_stall = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check("post_rst_quiet", out_valid, 0);
            cycle();
        end
        send(300, 400, 0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cordic_pipe.md
# cordic_pipe

Parametrised, fully pipelined CORDIC engine; successor to the fixed 13-bit, 10-stage rotation-only pipeline. Adds configurable width, stage count and fractional format, a per-sample rotation/vectoring mode bit, valid/ready flow control with whole-pipeline stall, and optional gain compensation. It sits between the sample front end and the polar/rectangular consumers in the datapath, one sample accepted per cycle when not stalled.

## Interface
- WIDTH, 13: two's-complement width of x, y, z.
- FRAC, 10: fractional bits of x, y, z (angles in radians, Q(WIDTH-FRAC).FRAC); requires FRAC <= WIDTH-3.
- STAGES, 10: number of micro-rotation stages, 1..16; stage i shifts by i.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  pipeline accepts a sample this cycle.
- in_mode  in  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0).
- in_x, in_y, in_z  in  WIDTH each  input vector and angle.
- out_valid  out  1  output sample present.
- out_ready  in  1  downstream accepts output.
- out_mode  out  1  mode of the output sample.
- out_x, out_y, out_z  out  WIDTH each  result.

## Operation
- Stage i (0..STAGES-1) registers x, y, z, mode, valid.
- Direction d: rotation: d=+1 if z >= 0 (sign bit clear), else -1; vectoring: d=+1 if y < 0, else -1.
- d=+1: x' = x - (y>>>i), y' = y + (x>>>i), z' = z - A_i; d=-1: signs swapped on all three terms.
- >>> is arithmetic shift (truncation toward minus infinity); all adds wrap modulo 2^WIDTH, no saturation.
- A_i = round(atan(2^-i) * 2^FRAC), generated at elaboration. Defaults: 804, 475, 251, 127, 64, 32, 16, 8, 4, 2.
- Convergence: caller guarantees |z| <= 1.74 rad (rotation) or x > 0 (vectoring), and gain growth does not overflow WIDTH.
- Mode bit travels unchanged with its sample; mixed modes back-to-back are legal.
- Bubbles (valid=0) travel through the pipe; they are not collapsed.

## Timing
- Reset: every valid bit 0, all data registers 0; hence out_valid=0, out_mode=0, out_x=out_y=out_z=0, in_ready=1.
- in_ready = !(out_valid && !out_ready) (combinational from out_ready).
- Stall: out_valid=1 and out_ready=0 freezes every stage; outputs held stable, in_ready=0; a sample offered while in_ready=0 is not captured and upstream must hold it.
- Advance: when in_ready=1, every stage shifts one position; input captured when in_valid=1, bubble otherwise.
- Latency: STAGES cycles from acceptance to out_valid (STAGES+1 with gain compensation), absent stalls.
- Throughput: one sample per cycle while out_ready=1.
- rst asserted mid-operation: all in-flight samples discarded immediately; first post-reset output only after a new acceptance.

## Configuration
- CORDIC_GAIN_COMP_EN defined: extra final register stage multiplies out_x and out_y by KINV = round(0.6072529 * 2^FRAC) (622 default), result >>> FRAC, truncated to WIDTH; out_z passes through. Latency STAGES+1; magnitude gain ~1.
- Undefined: no extra stage; out_x/out_y carry CORDIC gain K ~ 1.6468 (for STAGES=10); latency STAGES.

## Test plan
- Reset/idle: assert rst, release, hold in_valid=0 for 20 cycles -> out_valid=0, out_x/y/z=0, in_ready=1 throughout.
- Rotation (no gain comp): x=622, y=0, z=0, mode 0 -> after 10 cycles x=1024±4, y=0±4, z within ±2; z=804 -> x=y=724±6.
- Vectoring: x=300, y=400, z=0, mode 1 -> x=823±6 (500*K), y=0±4, z=950±3; alternate modes every cycle, each result matches its isolated run.
- Backpressure: stream 30 samples, drop out_ready for 5 cycles at random points -> no loss, no duplication, order preserved, outputs stable during stall, in_ready=0 while stalled.
- Reset mid-stream: assert rst with 6 samples in flight -> out_valid falls immediately, none of the 6 ever emerge; next accepted sample emerges after exactly STAGES cycles.
- Gain comp build (CORDIC_GAIN_COMP_EN): x=1000, y=0, z=0 rotation -> x=1000±6 after 11 cycles; STAGES=16, WIDTH=18, FRAC=14 build passes the rotation check scaled.
